// File: rtl/stall_mem_responder_if.sv
// Request/response bus between an initiator and the stalling memory responder.
// The initiator (master) presents requests; the responder (slave) returns registered status and data.
interface stall_mem_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr, createdump,
    input  DataOut, Done, Stall, CacheHit, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, createdump,
    output DataOut, Done, Stall, CacheHit, err
  );
endinterface

// File: rtl/stall_mem_responder.sv
// Word-addressed 16-bit memory with a one-entry tag: tag hits finish in one cycle,
// misses stall for LATENCY cycles. createdump halts the responder until reset.
module stall_mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  stall_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                r_state;
  state_t                w_next;

  logic [15:0]           r_mem [2**ADDR_BITS];

  logic [3:0]            r_cnt;
  logic                  r_tagValid;
  logic [15:1]           r_tag;
  logic [15:1]           r_addr;
  logic [15:0]           r_data;
  logic                  r_isWr;
  logic                  r_dump;
  logic [15:0]           r_dataOut;
  logic                  r_done;
  logic                  r_stall;
  logic                  r_hit;
  logic                  r_err;

  logic                  w_req;
  logic                  w_reqErr;
  logic                  w_hit;
  logic                  w_doneN;
  logic                  w_stallN;
  logic                  w_hitN;
  logic                  w_errN;
  logic                  w_accept;
  logic                  w_tagLoad;
  logic                  w_memWe;
  logic                  w_rdLoad;
  logic [ADDR_BITS-1:0]  w_idx;
  logic [15:0]           w_memData;
  logic [3:0]            w_cntN;
  logic                  w_dumpN;

  assign w_req    = bus.Rd | bus.Wr;
  assign w_reqErr = (bus.Rd & bus.Wr) | bus.Addr[0];
  assign w_hit    = r_tagValid && (bus.Addr[15:1] == r_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Counter is loaded with LATENCY-1 so completion at count 1 lands Done exactly LATENCY cycles after acceptance.
  always_comb begin
    w_next    = r_state;
    w_doneN   = 1'b0;
    w_stallN  = 1'b0;
    w_hitN    = 1'b0;
    w_errN    = 1'b0;
    w_accept  = 1'b0;
    w_tagLoad = 1'b0;
    w_memWe   = 1'b0;
    w_rdLoad  = 1'b0;
    w_idx     = bus.Addr[ADDR_BITS:1];
    w_memData = bus.DataIn;
    w_cntN    = r_cnt;
    w_dumpN   = r_dump;
    case (r_state)
      IDLE: begin
        if (bus.createdump) begin
          w_next = HALTED;
        end else if (w_req) begin
          if (w_reqErr) begin
            w_doneN = 1'b1;
            w_errN  = 1'b1;
          end else if (w_hit) begin
            w_doneN  = 1'b1;
            w_hitN   = 1'b1;
            w_memWe  = bus.Wr;
            w_rdLoad = bus.Rd;
          end else begin
            w_accept = 1'b1;
            w_stallN = 1'b1;
            w_cntN   = CNT_LOAD;
            w_dumpN  = 1'b0;
            w_next   = BUSY;
          end
        end
      end
      BUSY: begin
        w_dumpN   = r_dump | bus.createdump;
        w_idx     = r_addr[ADDR_BITS:1];
        w_memData = r_data;
        if (r_cnt <= 4'd1) begin
          w_doneN   = 1'b1;
          w_memWe   = r_isWr;
          w_rdLoad  = ~r_isWr;
          w_tagLoad = 1'b1;
          w_cntN    = 4'd0;
          w_next    = w_dumpN ? HALTED : IDLE;
        end else begin
          w_cntN   = r_cnt - 4'd1;
          w_stallN = 1'b1;
        end
      end
      HALTED: begin
        w_next = HALTED;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // The array has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (w_memWe && !rst) r_mem[w_idx] <= w_memData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_tagValid <= 1'b0;
      r_tag      <= '0;
      r_addr     <= '0;
      r_data     <= 16'h0000;
      r_isWr     <= 1'b0;
      r_dump     <= 1'b0;
      r_dataOut  <= 16'h0000;
      r_done     <= 1'b0;
      r_stall    <= 1'b0;
      r_hit      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cnt   <= w_cntN;
      r_dump  <= w_dumpN;
      r_done  <= w_doneN;
      r_stall <= w_stallN;
      r_hit   <= w_hitN;
      r_err   <= w_errN;
      if (w_accept) begin
        r_addr <= bus.Addr[15:1];
        r_data <= bus.DataIn;
        r_isWr <= bus.Wr;
      end
      if (w_tagLoad) begin
        r_tag      <= r_addr;
        r_tagValid <= 1'b1;
      end
      if (w_rdLoad) r_dataOut <= r_mem[w_idx];
    end
  end

  assign bus.DataOut  = r_dataOut;
  assign bus.Done     = r_done;
  assign bus.Stall    = r_stall;
  assign bus.CacheHit = r_hit;
  assign bus.err      = r_err;

endmodule
